// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the HALT state and the
// sticky misaligned-redirect error).
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1
    } fetch_state_e;
`endif

    // One queued fetch result as seen by decode.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with push/pop/flush, occupancy count and a
// combinational view of the head entry. Push while full is accepted only when
// a pop happens in the same cycle. Flush wins over push and pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues word requests to imem under a
// credit rule that guarantees every response has a queue slot, and hands
// {pc, instr} pairs to decode over valid/ready. Redirects flush the queue and
// mark every in-flight response as stale.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// target sets a sticky error_o and parks the stage in HALT until reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no new requests; in-flight responses still land in the queue
// ST_FETCH | issue requests whenever credit allows
// ST_HALT  | (macro only) misaligned redirect seen; no requests, responses dropped
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_valid_i,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               error_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [OUT_W-1:0]  drop_q, drop_d;

    logic [SUM_W-1:0]  credit_used;
    logic              req;
    logic              resp_keep;
    logic              halted;
    logic              misalign;

    fetch_entry_t      q_wdata;
    fetch_entry_t      q_head;
    logic [CNT_W-1:0]  q_count;
    logic              q_pop;
    logic [ADDR_W-1:0] tag_head;
    logic [OUT_W-1:0]  unused_tag_count;

    // Request decision and queue control for this cycle.
    always_comb begin
        halted   = 1'b0;
        misalign = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted   = (state_q == ST_HALT);
        misalign = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`endif
        // Queued entries plus in-flight requests (stale ones included) must
        // never exceed the queue, so a response always finds a free slot.
        credit_used = SUM_W'(q_count) + SUM_W'(outstanding_q);
        req = (state_q == ST_FETCH)
              && (credit_used < SUM_W'(DEPTH))
              && (outstanding_q < OUT_W'(MAX_OUT))
              && !redirect_i;
        resp_keep     = imem_valid_i && (drop_q == '0) && !redirect_i && !halted;
        q_wdata.pc    = tag_head;
        q_wdata.instr = imem_instr_i;
        q_pop         = (q_count != '0) && ready_i;
    end

    // Next PC, in-flight accounting and state transitions.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + OUT_W'(req) - OUT_W'(imem_valid_i);
        drop_d        = drop_q;

        if (redirect_i) begin
            // Everything still in flight after this edge belongs to the old
            // path, including nothing that lands this cycle (it is dropped now).
            drop_d     = outstanding_q - OUT_W'(imem_valid_i);
            fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end else begin
            if (imem_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - OUT_W'(1);
            end
            if (req) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end

        case (state_q)
            ST_IDLE:  if (start_i)  state_d = ST_FETCH;
            ST_FETCH: if (!start_i) state_d = ST_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT:  state_d = ST_HALT;
`endif
            default:  state_d = ST_IDLE;
        endcase

        if (misalign) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = ST_HALT;
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= {PC_RESET[ADDR_W-1:2], 2'b00};
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic error_q, error_d;

    // Sticky misaligned-redirect flag; only reset clears it.
    always_comb begin
        error_d = error_q | misalign;
    end

    // Error flag register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign error_o       = 1'b0;
`endif

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (resp_keep),
        .data_i  (q_wdata),
        .pop_i   (q_pop),
        .flush_i (redirect_i),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // Holds the PC of every in-flight request; popped by every response,
    // stale or not, so tags stay aligned with imem order across redirects.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUT)
    ) u_tag_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req),
        .data_i  (fetch_pc_q),
        .pop_i   (imem_valid_i),
        .flush_i (1'b0),
        .head_o  (tag_head),
        .count_o (unused_tag_count)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = fetch_pc_q;
    assign valid_o     = (q_count != '0);
    assign pc_o        = valid_o ? q_head.pc : '0;
    assign instr_o     = valid_o ? q_head.instr : '0;

`ifndef SYNTHESIS
    // Protocol and occupancy checks.
    always @(posedge clk_i) begin
        if (rst_i) begin
            assert (!(imem_valid_i && (outstanding_q == '0)))
                else $error("imem response with no request outstanding");
            assert (int'(q_count) <= DEPTH)
                else $error("fetch queue count above DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: an imem responder with programmable latency,
// an epoch-tagged queue model of what decode must see, and directed phases.
module tb_instr_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i = 1'b0;
    logic [31:0] imem_instr_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        error_o;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_valid_i  (imem_valid_i),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    ent_t        mq[$];
    pend_t       pend[$];
    logic [31:0] dlog[$];
    logic [31:0] ilog[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          dropped = 0;
    int          max_pend = 0;
    int          first_valid = -1;
    int          cyc_base = 0;
    logic        m_fetch = 1'b0;
    logic        m_halt = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] exp_next = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic  exp_req;
        logic  exp_valid;
        logic  s_req;
        logic  s_pop;
        pend_t p;
        imem_valid_i = 1'b0;
        imem_instr_i = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_valid_i = 1'b1;
            imem_instr_i = mem_word(pend[0].addr);
        end
        @(negedge clk_i);
        exp_valid = (mq.size() > 0);
        exp_req   = m_fetch && !m_halt && (mq.size() + pend.size() < DEPTH)
                    && (pend.size() < MAX_OUT) && !redirect_i;
        chk("valid_o", valid_o, exp_valid);
        if (exp_valid) begin
            chk("pc_o", pc_o, mq[0].pc);
            chk("instr_o", instr_o, mq[0].instr);
        end
        chk("imem_req_o", imem_req_o, exp_req);
        if (exp_req) chk("imem_addr_o", imem_addr_o, m_pc);
        chk("error_o", error_o, m_halt);
        if (valid_o && first_valid < 0) first_valid = cyc - cyc_base;
        s_req = imem_req_o;
        s_pop = valid_o && ready_i;
        if (s_pop) begin
            dlog.push_back(pc_o);
            ilog.push_back(instr_o);
            chk("deliver_seq", pc_o, exp_next);
            exp_next += 32'd4;
        end
        @(posedge clk_i);
        if (exp_valid && ready_i) void'(mq.pop_front());
        if (imem_valid_i) begin
            p = pend.pop_front();
            if (p.epoch == epoch && !redirect_i && !m_halt)
                mq.push_back('{pc: p.addr, instr: mem_word(p.addr)});
            else
                dropped++;
        end
        if (s_req) begin
            pend.push_back('{addr: m_pc, epoch: epoch, due: cyc + lat});
            m_pc += 32'd4;
        end
        if (redirect_i) begin
            mq.delete();
            epoch++;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc_i[1:0] != 2'b00) m_halt = 1'b1;
`endif
            m_pc     = {redirect_pc_i[31:2], 2'b00};
            exp_next = m_pc;
        end
        m_fetch = start_i;
        if (pend.size() > max_pend) max_pend = pend.size();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        imem_valid_i = 1'b0;
        imem_instr_i = '0;
        mq.delete();
        pend.delete();
        m_fetch = 1'b0;
        m_halt = 1'b0;
        m_pc = '0;
        exp_next = '0;
        epoch++;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_error", error_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        start_i = 1'b0;
        ready_i = 1'b1;
        n = 0;
        while ((mq.size() > 0 || pend.size() > 0) && n < 30) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(mq.size() + pend.size()), 32'd0);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int d0;
        int n;

        // Phase A: streaming at latency 1
        do_reset();
        lat = 1;
        start_i = 1'b1;
        ready_i = 1'b1;
        cyc_base = cyc;
        repeat (12) cycle();
        chk("first_valid_cycle", 32'(first_valid), 32'd3);
        chk("deliver0_pc", dlog[0], 32'h0000_0000);
        chk("deliver1_pc", dlog[1], 32'h0000_0004);
        chk("deliver2_pc", dlog[2], 32'h0000_0008);
        chk("deliver0_instr", ilog[0], 32'hFFFF_0000);
        chk("deliver1_instr", ilog[1], 32'hFFFB_0004);

        // Phase B: decode stalls, queue fills, then resumes
        ready_i = 1'b0;
        repeat (10) cycle();
        chk("stall_queue_full", 32'(mq.size()), 32'd4);
        chk("stall_no_outstanding", 32'(pend.size()), 32'd0);
        chk("stall_dut_valid", valid_o, 1'b1);
        ready_i = 1'b1;
        repeat (15) cycle();

        // Phase C: latency 3, outstanding cap
        drain();
        lat = 3;
        max_pend = 0;
        start_i = 1'b1;
        ready_i = 1'b1;
        repeat (30) cycle();
        chk("max_outstanding", 32'(max_pend), 32'd2);

        // Phase D: redirect with two queued and two in flight
        drain();
        ready_i = 1'b0;
        start_i = 1'b1;
        n = 0;
        while (!(mq.size() == 2 && pend.size() == 2) && n < 40) begin
            cycle();
            n++;
        end
        chk("setup_2q_2out", 32'(mq.size() * 10 + pend.size()), 32'd22);
        d0 = dropped;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        cycle();
        redirect_i = 1'b0;
        chk("valid_after_redirect", valid_o, 1'b0);
        ready_i = 1'b1;
        nd = dlog.size();
        n = 0;
        while (dlog.size() == nd && n < 20) begin
            cycle();
            n++;
        end
        chk("redirect_target_pc", dlog[nd], 32'h0000_0100);
        chk("redirect_target_instr", ilog[nd], 32'hFEFF_0100);
        chk("stale_dropped", 32'(dropped - d0), 32'd2);
        repeat (6) cycle();

        // Phase E: redirect coinciding with a response and a pop
        drain();
        lat = 1;
        start_i = 1'b1;
        ready_i = 1'b1;
        repeat (6) cycle();
        n = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc && mq.size() > 0) && n < 20) begin
            cycle();
            n++;
        end
        nd = dlog.size();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cycle();
        redirect_i = 1'b0;
        chk("pop_in_redirect_cycle", 32'(dlog.size()), 32'(nd + 1));
        nd = dlog.size();
        n = 0;
        while (dlog.size() == nd && n < 20) begin
            cycle();
            n++;
        end
        chk("same_cycle_redirect_pc", dlog[nd], 32'h0000_0200);
        repeat (4) cycle();

        // Phase F: misaligned redirect target
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        cycle();
        redirect_i = 1'b0;
        nd = dlog.size();
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (10) cycle();
        chk("halt_error", error_o, 1'b1);
        chk("halt_valid", valid_o, 1'b0);
        chk("halt_no_deliver", 32'(dlog.size()), 32'(nd));
        do_reset();
        chk("halt_cleared_by_reset", error_o, 1'b0);
`else
        n = 0;
        while (dlog.size() == nd && n < 20) begin
            cycle();
            n++;
        end
        chk("misaligned_resume_pc", dlog[nd], 32'h0000_0100);
        chk("misaligned_no_error", error_o, 1'b0);
        repeat (4) cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
